// File: rtl/greenhouse_telemetry_tx.sv
// Greenhouse uplink: snapshots monitor outputs and shifts a 6-byte UART 8N1 frame
// (sync, flags, growth, leaf, seq, xor checksum) on a period tick or an alert rising edge.
module greenhouse_telemetry_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FRAME_PERIOD = 50000000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fan,
  input  logic       irrigation,
  input  logic       humidity_control,
  input  logic       alert,
  input  logic [7:0] growth_status,
  input  logic [7:0] leaf_health,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] seq_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PER_W = $clog2(FRAME_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(FRAME_PERIOD - 1);
  localparam logic [3:0]       BIT_STOP  = 4'd9;
  localparam logic [2:0]       BYTE_LAST = 3'd5;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [PER_W-1:0] per_cnt;
  logic             pending, alert_q;
  logic             period_hit, alert_rise;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [3:0]       bit_idx, bit_nxt;     // 0 = start, 1..8 = data, 9 = stop
  logic [2:0]       byte_idx, byte_nxt;
  logic             frame_end;
  logic             tx_nxt;
  logic [7:0]       cur_byte;
  logic [2:0]       data_idx;
  logic [7:0]       seq;
  logic [7:0]       flags;
  logic [7:0]       frame_buf [0:5];

  assign period_hit = enable && (per_cnt == PER_LAST);
  assign alert_rise = enable && alert && !alert_q;
  assign flags      = {4'b0000, alert, humidity_control, irrigation, fan};
  assign seq_out    = seq;

  // Triggers coalesce into one pending flag; a trigger in the LOAD cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      pending <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      alert_q <= alert;
      if (!enable) begin
        per_cnt <= '0;
        pending <= 1'b0;
      end else begin
        per_cnt <= period_hit ? '0 : per_cnt + PER_W'(1);
        if (period_hit || alert_rise) pending <= 1'b1;
        else if (state == LOAD)       pending <= 1'b0;
      end
    end
  end

  // NOTE: the payload buffer has no reset; LOAD always rewrites it before any of it reaches tx.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      frame_buf[0] <= SYNC_BYTE;
      frame_buf[1] <= flags;
      frame_buf[2] <= growth_status;
      frame_buf[3] <= leaf_health;
      frame_buf[4] <= seq;
      frame_buf[5] <= SYNC_BYTE ^ flags ^ growth_status ^ leaf_health ^ seq;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_nxt     = bit_idx;
    byte_nxt    = byte_idx;
    frame_end   = 1'b0;
    unique case (state)
      IDLE: if (pending) state_nxt = LOAD;
      LOAD: begin
        state_nxt   = SHIFT;
        clk_cnt_nxt = '0;
        bit_nxt     = '0;
        byte_nxt    = '0;
      end
      SHIFT: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          if (bit_idx == BIT_STOP) begin
            bit_nxt = '0;
            if (byte_idx == BYTE_LAST) begin
              state_nxt = IDLE;
              frame_end = 1'b1;
            end else begin
              byte_nxt = byte_idx + 3'd1;
            end
          end else begin
            bit_nxt = bit_idx + 4'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx is decoded from the next bit position so the line flop changes on the same edge as the counters.
  always_comb begin
    cur_byte = frame_buf[byte_nxt];
    data_idx = bit_nxt[2:0] - 3'd1;
    tx_nxt   = 1'b1;
    if (state_nxt == SHIFT) begin
      if (bit_nxt == 4'd0)          tx_nxt = 1'b0;
      else if (bit_nxt != BIT_STOP) tx_nxt = cur_byte[data_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      seq        <= 8'h00;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_idx    <= bit_nxt;
      byte_idx   <= byte_nxt;
      tx         <= tx_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= frame_end;
      if (frame_end) seq <= seq + 8'd1;
    end
  end

endmodule

// File: tb/tb_greenhouse_telemetry_tx.sv
// Directed bench for greenhouse_telemetry_tx: decodes tx frames bit by bit and
// compares against hand-computed bytes, timing, coalescing, reset and enable behaviour.
module tb_greenhouse_telemetry_tx;

  localparam int CPB = 4;
  localparam int FP  = 1000;
  localparam int NS  = 60 * CPB;

  logic       clk = 1'b0;
  logic       rst_n, enable, fan, irrigation, humidity_control, alert;
  logic [7:0] growth_status, leaf_health;
  logic       tx, busy, frame_done;
  logic [7:0] seq_out;

  greenhouse_telemetry_tx #(
    .CLKS_PER_BIT (CPB),
    .FRAME_PERIOD (FP),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .fan              (fan),
    .irrigation       (irrigation),
    .humidity_control (humidity_control),
    .alert            (alert),
    .growth_status    (growth_status),
    .leaf_health      (leaf_health),
    .tx               (tx),
    .busy             (busy),
    .frame_done       (frame_done),
    .seq_out          (seq_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx [6];
  logic       rx_ok;

  int busy_run = 0;
  int last_busy_len = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      last_busy_len <= busy_run;
      busy_run      <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart_enable();
    @(negedge clk) enable = 1'b0;
    @(negedge clk) enable = 1'b1;
  endtask

  task automatic wait_busy(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Captures one whole frame sample-per-cycle; mode injects stimulus mid-frame.
  task automatic rx_frame(input int mode);
    logic s [NS];
    logic lvl;
    int   w;
    rx_ok = 1'b1;
    w = 0;
    while (tx !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) rx_ok = 1'b0;
    s[0] = tx;
    for (int i = 1; i < NS; i++) begin
      @(negedge clk);
      s[i] = tx;
      case (mode)
        1: begin
          if (i == 100) alert = 1'b0;
          if (i == 104) alert = 1'b1;
        end
        2: begin
          if (i == 40) alert = 1'b0;
          if (i == 60) alert = 1'b1;
          if (i == 200) begin
            fan = 1'b1; irrigation = 1'b1; humidity_control = 1'b1;
            growth_status = 8'h80; leaf_health = 8'h00;
          end
        end
        3: if (i == 100) enable = 1'b0;
        default: ;
      endcase
    end
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 10; k++) begin
        lvl = s[(j * 10 + k) * CPB];
        for (int c = 1; c < CPB; c++)
          if (s[(j * 10 + k) * CPB + c] !== lvl) rx_ok = 1'b0;
        if (k == 0 && lvl !== 1'b0) rx_ok = 1'b0;
        if (k == 9 && lvl !== 1'b1) rx_ok = 1'b0;
        if (k >= 1 && k <= 8) rx[j][k-1] = lvl;
      end
    end
  endtask

  function automatic logic [47:0] rx_bytes();
    return {rx[0], rx[1], rx[2], rx[3], rx[4], rx[5]};
  endfunction

  initial begin
    int lat;
    int n_busy, n_low, n_done;
    logic [7:0] exp_seq;

    rst_n = 1'b0; enable = 1'b0; alert = 1'b0;
    fan = 1'b1; irrigation = 1'b0; humidity_control = 1'b1;
    growth_status = 8'hFF; leaf_health = 8'h50;
    step(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_seq", seq_out, 8'h00);

    // Periodic frame straight out of reset.
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    wait_busy(1200, lat);
    check("p1_start_latency", lat, 1001);
    rx_frame(0);
    check("p1_framing", rx_ok, 1);
    check("p1_bytes", rx_bytes(), 48'hA5_05_FF_50_00_0F);
    step(1);
    check("p1_done_pulse", frame_done, 1);
    check("p1_busy_low", busy, 0);
    check("p1_seq_inc", seq_out, 8'h01);
    check("p1_tx_idle", tx, 1);
    step(1);
    check("p1_done_single", frame_done, 0);
    step(2);
    check("p1_busy_len", last_busy_len, 241);

    // Alert rising edge mid-period; holding alert high must not retrigger.
    restart_enable();
    growth_status = 8'h3C; leaf_health = 8'h21;
    step(100);
    alert = 1'b1;
    wait_busy(10, lat);
    check("p2_alert_latency", lat, 2);
    rx_frame(0);
    check("p2_framing", rx_ok, 1);
    check("p2_bytes", rx_bytes(), 48'hA5_0D_3C_21_01_B4);
    n_busy = 0;
    repeat (500) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
    end
    check("p2_no_retrigger", n_busy, 0);

    // Alert edge and period expiry both during a frame: one follow-on frame.
    alert = 1'b0;
    fan = 1'b0; irrigation = 1'b1; humidity_control = 1'b0;
    growth_status = 8'h12; leaf_health = 8'h64;
    restart_enable();
    step(898);
    alert = 1'b1;
    wait_busy(10, lat);
    check("p3_alert_latency", lat, 2);
    rx_frame(2);
    check("p3a_framing", rx_ok, 1);
    check("p3a_bytes", rx_bytes(), 48'hA5_0A_12_64_02_DB);
    step(1);
    check("p3_done_pulse", frame_done, 1);
    check("p3_gap_busy", busy, 0);
    check("p3_gap_tx", tx, 1);
    step(1);
    check("p3_load_busy", busy, 1);
    check("p3_load_tx", tx, 1);
    rx_frame(0);
    check("p3b_framing", rx_ok, 1);
    check("p3b_bytes", rx_bytes(), 48'hA5_0F_80_00_03_29);
    n_busy = 0;
    repeat (400) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
    end
    check("p3_single_followon", n_busy, 0);

    // 256 back-to-back frames: seq field walks and wraps, checksum every frame.
    alert = 1'b0;
    fan = 1'b1; irrigation = 1'b1; humidity_control = 1'b0;
    growth_status = 8'h5A; leaf_health = 8'h33;
    restart_enable();
    step(1);
    alert = 1'b1;
    exp_seq = 8'h04;
    for (int f = 0; f < 256; f++) begin
      wait_busy(20, lat);
      check("p4_start_gap", lat, 2);
      rx_frame((f == 255) ? 3 : 1);
      check("p4_framing", rx_ok, 1);
      check("p4_flags", rx[1], 8'h0B);
      check("p4_seq_field", rx[4], exp_seq);
      check("p4_checksum", rx[5], rx[0] ^ rx[1] ^ rx[2] ^ rx[3] ^ rx[4]);
      exp_seq = exp_seq + 8'd1;
    end
    step(1);
    check("p4_done_pulse", frame_done, 1);
    check("p4_seq_wrapped", seq_out, 8'h04);

    // Reset during B2 data bits aborts the frame at once.
    alert = 1'b0;
    fan = 1'b0; irrigation = 1'b0; humidity_control = 1'b1;
    growth_status = 8'h01; leaf_health = 8'h63;
    restart_enable();
    step(1);
    alert = 1'b1;
    wait_busy(10, lat);
    check("p5_alert_latency", lat, 2);
    step(91);
    check("p5_busy_mid", busy, 1);
    check("p5_tx_b2_bit1", tx, 0);
    #1;
    rst_n = 1'b0;
    alert = 1'b0;
    #1;
    check("p5_rst_tx", tx, 1);
    check("p5_rst_busy", busy, 0);
    check("p5_rst_seq", seq_out, 8'h00);
    step(2);
    rst_n = 1'b1;
    wait_busy(1200, lat);
    check("p5_restart_latency", lat, 1001);
    rx_frame(0);
    check("p5_framing", rx_ok, 1);
    check("p5_bytes", rx_bytes(), 48'hA5_04_01_63_00_C3);
    step(1);
    check("p5_done_pulse", frame_done, 1);
    check("p5_seq_inc", seq_out, 8'h01);
    enable = 1'b0;

    // Disabled: no activity despite alert toggling; re-enable restarts the period.
    n_low = 0; n_done = 0; n_busy = 0;
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge clk);
      if (i % 50 == 0) alert = ~alert;
      if (tx !== 1'b1) n_low++;
      if (frame_done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    check("p6_tx_idle", n_low, 0);
    check("p6_no_done", n_done, 0);
    check("p6_no_busy", n_busy, 0);
    alert = 1'b0;
    step(2);
    enable = 1'b1;
    wait_busy(1200, lat);
    check("p6_enable_latency", lat, 1001);
    rx_frame(0);
    check("p6_framing", rx_ok, 1);
    check("p6_seq_field", rx[4], 8'h01);
    check("p6_checksum", rx[5], rx[0] ^ rx[1] ^ rx[2] ^ rx[3] ^ rx[4]);
    step(1);
    check("p6_done_pulse", frame_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
